// File: rtl/rv_operand_fetch_if.sv
// Decode/register-file/write-back/execute signal bundle for the operand fetch stage.
// The stage itself sits on the slave side; the surrounding pipeline drives the master side.
interface rv_operand_fetch_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  // decode side
  logic            i_valid;
  logic            o_ready;
  logic [RA_W-1:0] i_rs1;
  logic [RA_W-1:0] i_rs2;
  logic [RA_W-1:0] i_rd;
  logic            i_rd_we;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  // register file
  logic [RA_W-1:0] o_rf_rs1;
  logic [RA_W-1:0] o_rf_rs2;
  logic [XLEN-1:0] i_rf_data1;
  logic [XLEN-1:0] i_rf_data2;
  // write-back
  logic            i_wb_write;
  logic [RA_W-1:0] i_wb_rd;
  logic [XLEN-1:0] i_wb_data;
  // execute side
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_op1;
  logic [XLEN-1:0] o_op2;
  logic [RA_W-1:0] o_rd;
  logic            o_rd_we;
  logic [XLEN-1:0] o_pc;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_pc, i_flush,
    input  i_rf_data1, i_rf_data2,
    input  i_wb_write, i_wb_rd, i_wb_data,
    input  i_ready,
    output o_ready, o_rf_rs1, o_rf_rs2,
    output o_valid, o_op1, o_op2, o_rd, o_rd_we, o_pc
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_rd, i_rd_we, i_pc, i_flush,
    output i_rf_data1, i_rf_data2,
    output i_wb_write, i_wb_rd, i_wb_data,
    output i_ready,
    input  o_ready, o_rf_rs1, o_rf_rs2,
    input  o_valid, o_op1, o_op2, o_rd, o_rd_we, o_pc
  );
endinterface

// File: rtl/rv_operand_fetch.sv
// Operand fetch stage: drives register-file read addresses, forces x0 to zero and bypasses
// the write-back that lands on the same edge the file samples its (registered) read.
module rv_operand_fetch #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic             i_clk,
  input logic             i_reset,
  rv_operand_fetch_if.slave bus
);

  logic            valid_q;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [RA_W-1:0] rd_q;
  logic            rd_we_q;
  logic [XLEN-1:0] pc_q;
  logic            byp1_q;
  logic            byp2_q;
  logic [XLEN-1:0] byp_data_q;

  logic            ready;
  logic            accept;
  logic [RA_W-1:0] rf_rs1;
  logic [RA_W-1:0] rf_rs2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  assign ready  = !valid_q | bus.i_ready;
  assign accept = bus.i_valid & ready & !bus.i_flush;

  // While stalled the held addresses are re-read every cycle, so later write-backs reach the operands.
  assign rf_rs1 = accept ? bus.i_rs1 : rs1_q;
  assign rf_rs2 = accept ? bus.i_rs2 : rs2_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      pc_q       <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
    end else begin
      if (bus.i_flush)     valid_q <= 1'b0;
      else if (accept)     valid_q <= 1'b1;
      else if (bus.i_ready) valid_q <= 1'b0;

      if (accept) begin
        rs1_q   <= bus.i_rs1;
        rs2_q   <= bus.i_rs2;
        rd_q    <= bus.i_rd;
        rd_we_q <= bus.i_rd_we;
        pc_q    <= bus.i_pc;
      end

      // The file returns the pre-write value for a same-edge write, so capture the write-back instead.
      byp1_q     <= bus.i_wb_write & (bus.i_wb_rd == rf_rs1) & (rf_rs1 != '0);
      byp2_q     <= bus.i_wb_write & (bus.i_wb_rd == rf_rs2) & (rf_rs2 != '0);
      byp_data_q <= bus.i_wb_data;
    end
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rs1_q != '0) op1 = byp1_q ? byp_data_q : bus.i_rf_data1;
    if (rs2_q != '0) op2 = byp2_q ? byp_data_q : bus.i_rf_data2;
  end

  assign bus.o_ready  = ready;
  assign bus.o_rf_rs1 = rf_rs1;
  assign bus.o_rf_rs2 = rf_rs2;
  assign bus.o_valid  = valid_q;
  assign bus.o_op1    = op1;
  assign bus.o_op2    = op2;
  assign bus.o_rd     = rd_q;
  assign bus.o_rd_we  = rd_we_q;
  assign bus.o_pc     = pc_q;

endmodule

// File: tb/tb_rv_operand_fetch.sv
// Self-checking bench for rv_operand_fetch: directed vector table, hand sequences for stall,
// flush and reset, then random traffic against an architectural register-value model.
module tb_rv_operand_fetch;

  logic i_clk;
  logic i_reset;

  rv_operand_fetch_if #(.XLEN(32), .RA_W(5)) bus ();

  rv_operand_fetch #(.XLEN(32), .RA_W(5)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file model: registered 1-cycle read returning the pre-write value on a same-edge write.
  logic [31:0] regs [32];

  function automatic logic [31:0] init_val(input int i);
    return (i == 7) ? 32'h11 : 32'h100 + i;
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (bus.i_wb_write) begin
      regs[bus.i_wb_rd] <= bus.i_wb_data;
    end
    bus.i_rf_data1 <= regs[bus.o_rf_rs1];
    bus.i_rf_data2 <= regs[bus.o_rf_rs2];
  end

  // Architectural view: the operand of a held source is simply that register's current value.
  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : regs[r];
  endfunction

  task automatic drive(input logic v, input logic rdy, input logic fl,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] pc,
                       input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    bus.i_valid    = v;
    bus.i_ready    = rdy;
    bus.i_flush    = fl;
    bus.i_rs1      = rs1;
    bus.i_rs2      = rs2;
    bus.i_rd       = rd;
    bus.i_rd_we    = we;
    bus.i_pc       = pc;
    bus.i_wb_write = wbw;
    bus.i_wb_rd    = wbrd;
    bus.i_wb_data  = wbd;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [31:0] pc, input logic [4:0] rd);
    check({name, "_valid"}, bus.o_valid, v);
    check({name, "_op1"}, bus.o_op1, op1);
    check({name, "_op2"}, bus.o_op2, op2);
    check({name, "_pc"}, bus.o_pc, pc);
    check({name, "_rd"}, bus.o_rd, rd);
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] pc;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        e_valid;
    logic [31:0] e_op1, e_op2, e_pc;
    logic [4:0]  e_rd;
    logic        e_rd_we;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [31:0] pc,
                              input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                              input logic ev, input logic [31:0] eo1, input logic [31:0] eo2,
                              input logic [31:0] epc, input logic [4:0] erd, input logic ewe);
    vec_t t;
    t.valid = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rd_we = we; t.pc = pc;
    t.wb_write = wbw; t.wb_rd = wbrd; t.wb_data = wbd;
    t.e_valid = ev; t.e_op1 = eo1; t.e_op2 = eo2; t.e_pc = epc; t.e_rd = erd; t.e_rd_we = ewe;
    return t;
  endfunction

  vec_t tbl [11];

  // random-phase model state
  logic        m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_we;
  logic [31:0] m_pc;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0,  0, 32'h0,   1, 5, 32'h1234_5678, 0, 0, 0, 32'h0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0,  0, 32'h0,   0, 0, 32'h0,         0, 0, 0, 32'h0, 0, 0);
    tbl[2]  = mk(1, 5, 0, 10, 1, 32'h100, 0, 0, 32'h0,         1, 32'h1234_5678, 0, 32'h100, 10, 1);
    tbl[3]  = mk(1, 7, 5, 11, 0, 32'h104, 1, 7, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h104, 11, 0);
    tbl[4]  = mk(1, 0, 0, 12, 1, 32'h108, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 32'h108, 12, 1);
    tbl[5]  = mk(1, 7, 7, 13, 1, 32'h10C, 1, 7, 32'hCAFE_0001, 1, 32'hCAFE_0001, 32'hCAFE_0001, 32'h10C, 13, 1);
    tbl[6]  = mk(1, 1, 2, 1,  1, 32'h0,   0, 0, 32'h0,         1, 32'h101, 32'h102, 32'h0, 1, 1);
    tbl[7]  = mk(1, 3, 4, 2,  0, 32'h4,   0, 0, 32'h0,         1, 32'h103, 32'h104, 32'h4, 2, 0);
    tbl[8]  = mk(1, 5, 6, 3,  1, 32'h8,   0, 0, 32'h0,         1, 32'h1234_5678, 32'h106, 32'h8, 3, 1);
    tbl[9]  = mk(1, 7, 0, 4,  1, 32'hC,   0, 0, 32'h0,         1, 32'hCAFE_0001, 0, 32'hC, 4, 1);
    tbl[10] = mk(0, 0, 0, 0,  0, 32'h0,   0, 0, 32'h0,         0, 32'hCAFE_0001, 0, 32'hC, 4, 1);

    // ---------------- reset ----------------
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    i_reset = 1'b1;
    step();
    step();
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset_rd_we", bus.o_rd_we, 0);
    i_reset = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].valid, 1, 0, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rd_we, tbl[i].pc,
            tbl[i].wb_write, tbl[i].wb_rd, tbl[i].wb_data);
      #1;
      check($sformatf("v%0d_ready", i), bus.o_ready, 1);
      step();
      check_out($sformatf("v%0d", i), tbl[i].e_valid, tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_pc, tbl[i].e_rd);
      check($sformatf("v%0d_rd_we", i), bus.o_rd_we, tbl[i].e_rd_we);
    end

    // ---------------- stall with write-back to held rs2 ----------------
    drive(1, 1, 0, 1, 3, 9, 1, 32'h200, 0, 0, 0);
    step();
    check_out("stall_acc", 1, 32'h101, 32'h103, 32'h200, 9);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 6, 6, 20, 0, 32'h204, (c == 1), 3, 32'hA5A5_0001);
      #1;
      check($sformatf("stall%0d_ready", c), bus.o_ready, 0);
      check($sformatf("stall%0d_rf_rs2", c), bus.o_rf_rs2, 3);
      step();
      check_out($sformatf("stall%0d", c), 1, 32'h101, (c == 0) ? 32'h103 : 32'hA5A5_0001, 32'h200, 9);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("stall_drain_valid", bus.o_valid, 0);

    // ---------------- flush while holding (stalled), then while ready ----------------
    drive(1, 1, 0, 2, 4, 5, 1, 32'h300, 0, 0, 0);
    step();
    check_out("fl_acc", 1, 32'h102, 32'h104, 32'h300, 5);
    drive(1, 0, 1, 6, 6, 6, 0, 32'h304, 0, 0, 0);
    step();
    check_out("fl_stalled", 0, 32'h102, 32'h104, 32'h300, 5);
    drive(1, 1, 0, 2, 4, 8, 1, 32'h308, 0, 0, 0);
    step();
    check_out("fl_acc2", 1, 32'h102, 32'h104, 32'h308, 8);
    drive(1, 1, 1, 6, 6, 6, 0, 32'h30C, 0, 0, 0);
    step();
    check_out("fl_ready", 0, 32'h102, 32'h104, 32'h308, 8);

    // ---------------- asynchronous reset mid-operation ----------------
    drive(1, 1, 0, 1, 2, 3, 1, 32'h400, 0, 0, 0);
    step();
    check("rst_pre_valid", bus.o_valid, 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    i_reset = 1'b1;
    #1;
    check_out("rst_async", 0, 0, 0, 0, 0);
    step();
    #1;
    i_reset = 1'b0;
    step();
    check("rst_after_valid", bus.o_valid, 0);

    // ---------------- random traffic vs architectural model ----------------
    m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_we = 0; m_pc = 0;
    for (int n = 0; n < 400; n++) begin
      logic v, rdy, fl, acc, wbw, we;
      logic [4:0] rs1, rs2, rd, wbrd;
      logic [31:0] pc, wbd;
      v    = ($urandom % 4) != 0;
      rdy  = ($urandom % 4) != 0;
      fl   = ($urandom % 8) == 0;
      rs1  = 5'($urandom % 8);
      rs2  = 5'($urandom % 8);
      rd   = 5'($urandom);
      we   = 1'($urandom);
      pc   = $urandom;
      wbw  = 1'($urandom);
      wbrd = 5'($urandom % 8);
      wbd  = $urandom;
      drive(v, rdy, fl, rs1, rs2, rd, we, pc, wbw, wbrd, wbd);
      #1;
      acc = v && (!m_valid || rdy) && !fl;
      check("rnd_ready", bus.o_ready, !m_valid || rdy);
      check("rnd_rf_rs1", bus.o_rf_rs1, acc ? rs1 : m_rs1);
      check("rnd_rf_rs2", bus.o_rf_rs2, acc ? rs2 : m_rs2);
      @(posedge i_clk);
      if (fl) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_we = we; m_pc = pc;
      end else if (rdy) m_valid = 0;
      #1;
      check_out("rnd", m_valid, arch(m_rs1), arch(m_rs2), m_pc, m_rd);
      check("rnd_rd_we", bus.o_rd_we, m_we);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_operand_fetch.md
Name: rv_operand_fetch

Overview:
- Pipeline stage between decode and execute; drives the register-file read addresses and turns the file's registered (1-cycle) read data into execute operands.
- Forces x0 to zero. Bypasses the write-back value that lands on the same edge the register file samples its read, since the file returns the old value then.
- Valid/ready on both sides; operands stay correct while the stage is stalled.

Parameters:
- XLEN, 32, operand/data width
- RA_W, 5, register address width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_valid  in  1  decode has an instruction
- o_ready  out  1  stage accepts the instruction this cycle
- i_rs1  in  RA_W  source register 1 address
- i_rs2  in  RA_W  source register 2 address
- i_rd  in  RA_W  destination register
- i_rd_we  in  1  instruction writes rd
- i_pc  in  XLEN  instruction PC
- i_flush  in  1  kill the held instruction and any accept this cycle
- o_rf_rs1  out  RA_W  register-file read address 1
- o_rf_rs2  out  RA_W  register-file read address 2
- i_rf_data1  in  XLEN  register-file read data 1 (registered, 1-cycle)
- i_rf_data2  in  XLEN  register-file read data 2 (registered, 1-cycle)
- i_wb_write  in  1  write-back enable (same signal that drives the file's write)
- i_wb_rd  in  RA_W  write-back register
- i_wb_data  in  XLEN  write-back data
- o_valid  out  1  operands valid to execute
- i_ready  in  1  execute accepts
- o_op1  out  XLEN  operand 1
- o_op2  out  XLEN  operand 2
- o_rd  out  RA_W  held rd
- o_rd_we  out  1  held rd write enable
- o_pc  out  XLEN  held PC

Behaviour:
- Clock i_clk; reset i_reset is asynchronous and active-high.
- Reset values:
  - o_valid=0.
  - Held rs1/rs2/rd/pc=0; o_rd_we=0.
  - Bypass flags=0; bypass data=0.
  - o_op1/o_op2 read 0 (held rs are x0).
- Handshake:
  - o_ready = !o_valid | i_ready (combinational).
  - accept = i_valid & o_ready & !i_flush.
  - On accept: latch rs1, rs2, rd, rd_we, pc; o_valid=1 next cycle.
  - On o_valid & i_ready & !accept: o_valid=0.
  - Back-to-back accepts give full throughput.
- Read address mux (combinational):
  - o_rf_rsN = accept ? i_rsN : held rsN.
  - While stalled, the file re-reads the held address every cycle, so later write-backs propagate.
- Latency: accept at edge N gives o_valid with operands in cycle N+1. Operands come from i_rf_data sampled at edge N.
- Bypass, per source N, on every edge (not only accept):
  - byp_N <= i_wb_write & (i_wb_rd == o_rf_rsN) & (o_rf_rsN != 0).
  - byp_data_N <= i_wb_data.
- Operand select (combinational), in priority order:
  - held rsN==0 -> 0, regardless of i_rf_data.
  - else byp_N -> byp_data_N.
  - else i_rf_dataN.
- Stall: outputs and held fields stable while o_valid & !i_ready. Only o_opN may change, and only to reflect write-backs to the held rsN.
- Flush: i_flush=1 at an edge -> o_valid=0 next cycle; no accept that cycle; held fields unchanged. Flush wins over i_valid and i_ready.
- rs1==rs2 with matching write-back: both operands bypassed identically.
- Write-back to x0: never bypassed; operand stays 0.
- Reset mid-operation: the held instruction is dropped immediately (o_valid=0 asynchronously); nothing replays.
- No load-use or scoreboard stalls in this block; hazard stalls are upstream.

Test Plan:
- Reset, then write x5=0x1234_5678 via write-back; two cycles later accept rs1=5, rs2=0 -> next cycle o_valid=1, o_op1=0x1234_5678, o_op2=0.
- Accept rs1=7 on the same edge as write-back x7=0xDEAD_BEEF (file holds 0x11) -> o_op1=0xDEAD_BEEF, not 0x11.
- Hold i_ready=0 three cycles after accept rs2=3; write x3=0xA5A5_0001 during the stall -> o_op2 updates to 0xA5A5_0001. pc, rd and o_valid unchanged; o_ready=0 throughout.
- Stream 4 instructions with i_valid=i_ready=1 -> o_valid stays 1 for 4 consecutive cycles; pcs 0x0, 0x4, 0x8, 0xC appear in order.
- i_flush with i_valid=1 while holding an instruction -> o_valid=0 next cycle; the new instruction is not accepted.
- Write-back x0=0xFFFF_FFFF coinciding with accept rs1=0, rs2=0 -> o_op1=o_op2=0.
